mips_muldiv_unit: RTL and testbench
===================================

# mips_muldiv_unit

Multi-cycle multiply/divide unit sitting directly downstream of the MIPS register file. It consumes the two register read channels (rs, rt) and implements MULT, MULTU, DIV, DIVU into private HI/LO registers. It also drives a register-file write port for MFHI/MFLO and accepts MTHI/MTLO. The pipeline stalls on o_busy while an iterative operation runs.

## Interface
Parameters:
- N_BIT, 31: MSB index of data words (32-bit datapath).
- N_REG, 4: MSB index of register addresses (32 registers).

Ports:
- i_clk  in  1  single clock; all state updates on the rising edge.
- arst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  request strobe; accepted only when o_busy=0.
- i_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- i_rs_data  in  N_BIT+1  register file read channel 1 (dividend, multiplicand, or MTHI/MTLO source).
- i_rt_data  in  N_BIT+1  register file read channel 2 (divisor or multiplier).
- i_rd_addr  in  N_REG+1  destination register for MFHI/MFLO.
- o_busy  out  1  iterative operation in progress.
- o_done  out  1  one-cycle pulse when a mul/div result lands in HI/LO.
- o_dz  out  1  divide-by-zero flag, valid with o_done.
- o_hi, o_lo  out  N_BIT+1  current HI/LO contents.
- o_w_en, o_addr_w, o_w_data  out  1 / N_REG+1 / N_BIT+1  write port to the register file.

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - i_start with op 0/1 latches operand magnitudes, sign info, and op, clears the 6-bit iteration counter, and enters MUL.
  - i_start with op 2/3 enters DIV, except when i_rt_data=0: the unit goes straight to FIX with the dz flag set.
- Signed ops (MULT, DIV) take absolute values of the operands. Unsigned ops use the operands raw.
- MUL: 32 iterations of shift-add on a 64-bit accumulator, one per cycle.
- DIV: 32 iterations of restoring division, one quotient bit per cycle, 33-bit partial remainder.
- The counter reaching 31 moves MUL/DIV to FIX. FIX lasts one cycle, then the FSM returns to IDLE.
- FIX, multiply:
  - {HI,LO} = 64-bit product.
  - For MULT, the product is negated when operand signs differ.
- FIX, divide:
  - LO = quotient, negated when operand signs differ (signed only).
  - HI = remainder, carrying the sign of the dividend (signed only).
  - DIV 0x80000000 / 0xFFFFFFFF wraps naturally: LO=0x80000000, HI=0.
- FIX, divide by zero: LO=0xFFFFFFFF, HI=i_rs_data as latched, o_dz=1.
- MFHI/MFLO (IDLE only):
  - Next cycle, o_w_en=1, o_addr_w=i_rd_addr, o_w_data=HI or LO, for one cycle.
  - If i_rd_addr=0, o_w_en stays 0.
- MTHI/MTLO (IDLE only): HI or LO is written with i_rs_data at the accepting edge. No o_done pulse.
- i_start while o_busy=1 is ignored completely: no latch, no write.
- HI/LO change only in FIX or on MTHI/MTLO. During MUL/DIV, o_hi/o_lo keep their previous values.

## Timing
- Reset (arst_n=0, asynchronous, any state, including mid-iteration):
  - State returns to IDLE; counter, HI, LO, and accumulators clear.
  - o_busy, o_done, o_dz, o_w_en, o_addr_w, o_w_data all go to 0.
  - The result of the aborted operation is lost.
- Mul/div accepted at edge k:
  - o_busy=1 after edge k and stays high through edge k+32.
  - FIX executes at edge k+33: HI/LO are updated, o_done=1 for one cycle, o_busy=0.
  - Total latency: 33 cycles; a new request can be accepted at edge k+33+1.
- Divide-by-zero accepted at edge k: o_busy=1 after edge k; FIX at edge k+1 gives o_done=1, o_dz=1, o_busy=0.
- o_done and o_dz are single-cycle pulses, cleared on the following edge.
- MFHI issued in the o_done cycle returns the new HI. MFHI issued while busy is ignored.
- MTHI/MTLO are visible on o_hi/o_lo one cycle after acceptance.

## Test plan
- Reset: hold arst_n=0, then release -> o_hi=o_lo=0, o_busy=0, o_w_en=0. Assert arst_n=0 mid-MUL at iteration 10 -> IDLE immediately, HI/LO=0, no o_done.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU with the same operands -> HI=0x00000006, LO=0xFFFFFFEB.
- DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=100, rt=7 -> LO=14, HI=2. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- DIVU rs=5, rt=0 -> o_done and o_dz at cycle 1, LO=0xFFFFFFFF, HI=5.
- MTHI 0x12345678, then MFHI rd=9 -> o_w_en=1, o_addr_w=9, o_w_data=0x12345678. MFLO rd=0 -> o_w_en=0.
- Start MULT, then pulse i_start with MTLO 0xAAAA at cycle 5 -> ignored; final LO equals the product, not 0xAAAA.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS HI/LO unit: MULT/MULTU/DIV/DIVU plus MFHI/MFLO/MTHI/MTLO.
// Latency: mul/div 33 cycles, divide-by-zero 1 cycle, MFHI/MFLO write 1 cycle, MTHI/MTLO 1 cycle.
// Backpressure: o_busy high while an operation runs; i_start is ignored entirely while busy.
module mips_muldiv_unit #(
   parameter int N_BIT = 31,
   parameter int N_REG = 4
) (
   input  logic             i_clk,
   input  logic             arst_n,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [N_BIT:0]   i_rs_data,
   input  logic [N_BIT:0]   i_rt_data,
   input  logic [N_REG:0]   i_rd_addr,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_dz,
   output logic [N_BIT:0]   o_hi,
   output logic [N_BIT:0]   o_lo,
   output logic             o_w_en,
   output logic [N_REG:0]   o_addr_w,
   output logic [N_BIT:0]   o_w_data
);

   localparam int W = N_BIT + 1;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MFHI  = 3'd4;
   localparam logic [2:0] OP_MFLO  = 3'd5;
   localparam logic [2:0] OP_MTHI  = 3'd6;
   localparam logic [2:0] OP_MTLO  = 3'd7;

   localparam logic [5:0] LAST_ITER = 6'(N_BIT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [5:0]      r_cnt;
   logic [2*W-1:0]  r_acc;      // mul: {partial product, multiplier}; div: [W-1:0] dividend/quotient
   logic [W:0]      r_rem;      // div partial remainder
   logic [W-1:0]    r_b;        // multiplicand or divisor magnitude
   logic            r_neg_res;  // operand signs differ on a signed op
   logic            r_neg_rem;  // signed dividend was negative
   logic            r_is_div;
   logic            r_dz;
   logic [W-1:0]    r_hi;
   logic [W-1:0]    r_lo;
   logic            r_done;
   logic            r_dz_out;
   logic            r_w_en;
   logic [N_REG:0]  r_addr_w;
   logic [W-1:0]    r_w_data;

   logic            w_signed;
   logic            w_rs_neg;
   logic            w_rt_neg;
   logic [W-1:0]    w_rs_mag;
   logic [W-1:0]    w_rt_mag;
   logic            w_rt_zero;
   logic [W:0]      w_mul_sum;
   logic [2*W-1:0]  w_mul_nxt;
   logic [W:0]      w_rem_sh;
   logic [W+1:0]    w_diff;
   logic            w_ge;
   logic [2*W-1:0]  w_prod;
   logic [W-1:0]    w_quo;
   logic [W-1:0]    w_remd;

   // Operand conditioning and one iteration step of the multiplier and divider
   always_comb begin
      w_signed  = (i_op == OP_MULT) || (i_op == OP_DIV);
      w_rs_neg  = w_signed & i_rs_data[N_BIT];
      w_rt_neg  = w_signed & i_rt_data[N_BIT];
      w_rs_mag  = w_rs_neg ? (~i_rs_data + 1'b1) : i_rs_data;
      w_rt_mag  = w_rt_neg ? (~i_rt_data + 1'b1) : i_rt_data;
      w_rt_zero = (i_rt_data == '0);

      // shift-add: conditionally add multiplicand to the upper half, then shift right with carry
      w_mul_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_b} : {(W+1){1'b0}});
      w_mul_nxt = {w_mul_sum, r_acc[W-1:1]};

      // restoring division: shift next dividend bit in, subtract if it fits
      w_rem_sh  = {r_rem[W-1:0], r_acc[W-1]};
      w_diff    = {1'b0, w_rem_sh} - {2'b00, r_b};
      w_ge      = ~w_diff[W+1];

      // final sign correction applied in FIX
      w_prod    = r_neg_res ? (~r_acc + 1'b1) : r_acc;
      w_quo     = r_neg_res ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
      w_remd    = r_neg_rem ? (~r_rem[W-1:0] + 1'b1) : r_rem[W-1:0];
   end

   // State register
   always_ff @(posedge i_clk or negedge arst_n) begin
      if (!arst_n) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic; divide by zero skips the iterations and goes straight to FIX
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               if ((i_op == OP_MULT) || (i_op == OP_MULTU))
                  w_state_nxt = S_MUL;
               else if ((i_op == OP_DIV) || (i_op == OP_DIVU))
                  w_state_nxt = w_rt_zero ? S_FIX : S_DIV;
            end
         end
         S_MUL:   if (r_cnt == LAST_ITER) w_state_nxt = S_FIX;
         S_DIV:   if (r_cnt == LAST_ITER) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand latch, iteration, HI/LO commit and register-file write port
   always_ff @(posedge i_clk or negedge arst_n) begin
      if (!arst_n) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_rem     <= '0;
         r_b       <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_is_div  <= 1'b0;
         r_dz      <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
         r_dz_out  <= 1'b0;
         r_w_en    <= 1'b0;
         r_addr_w  <= '0;
         r_w_data  <= '0;
      end else begin
         r_done   <= 1'b0;
         r_dz_out <= 1'b0;
         r_w_en   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  case (i_op)
                     OP_MULT, OP_MULTU: begin
                        r_acc     <= {{W{1'b0}}, w_rt_mag};
                        r_b       <= w_rs_mag;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_neg_res <= w_rs_neg ^ w_rt_neg;
                        r_neg_rem <= 1'b0;
                        r_is_div  <= 1'b0;
                        r_dz      <= 1'b0;
                     end
                     OP_DIV, OP_DIVU: begin
                        // on divide by zero the raw dividend is kept for HI
                        r_acc     <= {{W{1'b0}}, (w_rt_zero ? i_rs_data : w_rs_mag)};
                        r_b       <= w_rt_mag;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_neg_res <= w_rs_neg ^ w_rt_neg;
                        r_neg_rem <= w_rs_neg;
                        r_is_div  <= 1'b1;
                        r_dz      <= w_rt_zero;
                     end
                     OP_MFHI, OP_MFLO: begin
                        r_w_en   <= (i_rd_addr != '0);
                        r_addr_w <= i_rd_addr;
                        r_w_data <= (i_op == OP_MFHI) ? r_hi : r_lo;
                     end
                     OP_MTHI: r_hi <= i_rs_data;
                     OP_MTLO: r_lo <= i_rs_data;
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               r_acc <= w_mul_nxt;
               r_cnt <= r_cnt + 6'd1;
            end
            S_DIV: begin
               r_acc[W-1:0] <= {r_acc[W-2:0], w_ge};
               r_rem        <= w_ge ? w_diff[W:0] : w_rem_sh;
               r_cnt        <= r_cnt + 6'd1;
            end
            S_FIX: begin
               if (r_dz) begin
                  r_hi <= r_acc[W-1:0];
                  r_lo <= '1;
               end else if (r_is_div) begin
                  r_hi <= w_remd;
                  r_lo <= w_quo;
               end else begin
                  r_hi <= w_prod[2*W-1:W];
                  r_lo <= w_prod[W-1:0];
               end
               r_done   <= 1'b1;
               r_dz_out <= r_dz;
            end
            default: ;
         endcase
      end
   end

   // Output mapping
   always_comb begin
      o_busy   = (r_state != S_IDLE);
      o_done   = r_done;
      o_dz     = r_dz_out;
      o_hi     = r_hi;
      o_lo     = r_lo;
      o_w_en   = r_w_en;
      o_addr_w = r_addr_w;
      o_w_data = r_w_data;
   end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: hand-computed HI/LO, latency, dz and write-port checks.
// Latency: each mul/div is expected to complete 33 edges after acceptance (1 for divide-by-zero).
// Backpressure: requests issued while busy must be dropped without side effects.
module tb_mips_muldiv_unit;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MFHI  = 3'd4;
   localparam logic [2:0] OP_MFLO  = 3'd5;
   localparam logic [2:0] OP_MTHI  = 3'd6;
   localparam logic [2:0] OP_MTLO  = 3'd7;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        i_start;
   logic [2:0]  i_op;
   logic [31:0] i_rs_data;
   logic [31:0] i_rt_data;
   logic [4:0]  i_rd_addr;
   logic        o_busy;
   logic        o_done;
   logic        o_dz;
   logic [31:0] o_hi;
   logic [31:0] o_lo;
   logic        o_w_en;
   logic [4:0]  o_addr_w;
   logic [31:0] o_w_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mips_muldiv_unit #(.N_BIT(31), .N_REG(4)) dut (
      .i_clk     (clk),
      .arst_n    (arst_n),
      .i_start   (i_start),
      .i_op      (i_op),
      .i_rs_data (i_rs_data),
      .i_rt_data (i_rt_data),
      .i_rd_addr (i_rd_addr),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_dz      (o_dz),
      .o_hi      (o_hi),
      .o_lo      (o_lo),
      .o_w_en    (o_w_en),
      .o_addr_w  (o_addr_w),
      .o_w_data  (o_w_data)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // present a request for exactly one rising edge; returns #1 after that edge
   task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] rd);
      @(negedge clk);
      i_start   = 1'b1;
      i_op      = op;
      i_rs_data = rs;
      i_rt_data = rt;
      i_rd_addr = rd;
      @(posedge clk);
      #1;
      i_start   = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (o_done !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int exp_lat, input logic exp_dz);
      int n;
      issue(op, rs, rt, 5'd0);
      chk({tag, "_busy"}, 64'(o_busy), 64'd1);
      wait_done(n);
      chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
      chk({tag, "_dz"}, 64'(o_dz), 64'(exp_dz));
      chk({tag, "_idle"}, 64'(o_busy), 64'd0);
      chk({tag, "_hilo"}, {o_hi, o_lo}, {exp_hi, exp_lo});
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, 64'({o_done, o_dz}), 64'd0);
   endtask

   initial begin
      int  n;
      logic saw_done;

      arst_n    = 1'b0;
      i_start   = 1'b0;
      i_op      = 3'd0;
      i_rs_data = '0;
      i_rt_data = '0;
      i_rd_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      arst_n = 1'b1;
      #1;
      chk("rst_hi",   64'(o_hi),   64'd0);
      chk("rst_lo",   64'(o_lo),   64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_wen",  64'(o_w_en), 64'd0);
      chk("rst_done", 64'(o_done), 64'd0);

      run_op("mult",  OP_MULT,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0);
      run_op("multu", OP_MULTU, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 33, 1'b0);
      run_op("div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
      run_op("divu",  OP_DIVU,  32'd100,       32'd7, 32'd2,         32'd14,        33, 1'b0);
      run_op("divov", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 1'b0);
      run_op("divz",  OP_DIVU,  32'd5,         32'd0, 32'd5,         32'hFFFF_FFFF, 1,  1'b1);

      // MTHI then MFHI to r9, MFLO to r0 is suppressed
      issue(OP_MTHI, 32'h1234_5678, 32'd0, 5'd0);
      chk("mthi_hi", 64'(o_hi), 64'h1234_5678);
      issue(OP_MFHI, 32'd0, 32'd0, 5'd9);
      chk("mfhi_wen",  64'(o_w_en),   64'd1);
      chk("mfhi_addr", 64'(o_addr_w), 64'd9);
      chk("mfhi_data", 64'(o_w_data), 64'h1234_5678);
      @(posedge clk);
      #1;
      chk("mfhi_wen_clr", 64'(o_w_en), 64'd0);
      issue(OP_MFLO, 32'd0, 32'd0, 5'd0);
      chk("mflo_r0_wen", 64'(o_w_en), 64'd0);

      // requests while busy are dropped; LO before this is 0xFFFFFFFF from divz
      issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0);
      repeat (3) @(posedge clk);
      issue(OP_MTLO, 32'h0000_AAAA, 32'd0, 5'd0);
      chk("busy_mtlo_lo", 64'(o_lo), 64'hFFFF_FFFF);
      issue(OP_MFHI, 32'd0, 32'd0, 5'd3);
      chk("busy_mfhi_wen", 64'(o_w_en), 64'd0);
      wait_done(n);
      chk("busy_done", 64'(o_done), 64'd1);
      chk("busy_hilo", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFEB);

      // asynchronous reset in the middle of a multiply
      issue(OP_MTHI, 32'h0000_0055, 32'd0, 5'd0);
      issue(OP_MULT, 32'd9, 32'd9, 5'd0);
      repeat (10) @(posedge clk);
      #2;
      arst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(o_busy), 64'd0);
      chk("arst_hilo", {o_hi, o_lo}, 64'd0);
      chk("arst_done", 64'(o_done), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      arst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (o_done === 1'b1) saw_done = 1'b1;
      end
      chk("arst_no_done", 64'(saw_done), 64'd0);
      chk("arst_hilo_after", {o_hi, o_lo}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
